// File: rtl/imem_serial_loader.sv
// Boot-time instruction memory loader.
// Takes a byte stream (CNT_LO, CNT_HI, 4*N little-endian data bytes, CHK).
// Each assembled 32-bit word is written to consecutive word addresses.
// The XOR of the data bytes is checked against CHK.
// cpu_run rises only after a verified load; any failure sets load_err.
// Ports:
//   CLK, Reset              clock, synchronous active-high reset
//   in_valid/in_byte        byte stream from upstream (e.g. UART RX)
//   in_ready                byte accepted when in_valid & in_ready at rising edge
//   mem_we/mem_addr/mem_wdata  one-cycle write strobe, byte address, word data
//   words_loaded            words written so far in this load
//   cpu_run                 program verified, release processor
//   load_err                load failed, sticky until Reset
module imem_serial_loader #(
  parameter int unsigned MEM_WORDS      = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [15:0] words_loaded,
  output logic        cpu_run,
  output logic        load_err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    DATA   = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          xfer;
  logic [7:0]    cnt_lo;
  logic [15:0]   n_words;
  logic [15:0]   n_rx;
  logic [1:0]    byte_idx;
  logic [23:0]   word_lo;
  logic [7:0]    chk;
  logic [TW-1:0] timer;
  logic          timing;
  logic          expired;
  logic          last_word;

  assign xfer      = in_valid & in_ready;
  assign n_rx      = {in_byte, cnt_lo};
  assign timing    = (state == CNT_HI) || (state == DATA) || (state == CHECK);
  // A byte arriving on the terminal count wins over the timeout.
  assign expired   = timing && (timer == TIMER_LAST) && !xfer;
  // words_loaded counts completed words, so this is the Nth word in flight.
  assign last_word = (words_loaded + 16'd1) == n_words;

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (xfer) state_nxt = CNT_HI;
      CNT_HI: begin
        if (xfer) begin
          if (n_rx == 16'd0)                    state_nxt = CHECK;
          else if ({16'd0, n_rx} > MEM_WORDS)   state_nxt = ERROR;
          else                                  state_nxt = DATA;
        end
      end
      DATA:   if (xfer && (byte_idx == 2'd3) && last_word) state_nxt = CHECK;
      CHECK:  if (xfer) state_nxt = (in_byte == chk) ? DONE : ERROR;
      default: ;
    endcase
    if (expired) state_nxt = ERROR;
  end

  // Datapath and registered outputs
  always_ff @(posedge CLK) begin
    if (Reset) begin
      in_ready     <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= 32'd0;
      words_loaded <= 16'd0;
      cpu_run      <= 1'b0;
      load_err     <= 1'b0;
      cnt_lo       <= 8'd0;
      n_words      <= 16'd0;
      byte_idx     <= 2'd0;
      word_lo      <= 24'd0;
      chk          <= 8'd0;
      timer        <= '0;
    end else begin
      in_ready <= (state_nxt == IDLE) || (state_nxt == CNT_HI) ||
                  (state_nxt == DATA) || (state_nxt == CHECK);
      cpu_run  <= (state_nxt == DONE);
      load_err <= (state_nxt == ERROR);
      mem_we   <= 1'b0;

      // Idle-cycle timer restarts on every byte and on every state change.
      if (xfer || !timing || (state_nxt != state)) timer <= '0;
      else                                         timer <= timer + TW'(1);

      if (xfer) begin
        unique case (state)
          IDLE:   cnt_lo <= in_byte;
          CNT_HI: begin
            n_words  <= n_rx;
            byte_idx <= 2'd0;
            chk      <= 8'd0;
          end
          DATA: begin
            chk      <= chk ^ in_byte;
            byte_idx <= byte_idx + 2'd1;
            unique case (byte_idx)
              2'd0: word_lo[7:0]   <= in_byte;
              2'd1: word_lo[15:8]  <= in_byte;
              2'd2: word_lo[23:16] <= in_byte;
              default: begin
                mem_we       <= 1'b1;
                mem_wdata    <= {in_byte, word_lo};
                mem_addr     <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
                words_loaded <= words_loaded + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
